// File: rtl/neg_pkg.sv
// Shared types for the two's-complement completion stage (neg_increment_seq).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package neg_pkg;

  // Operand width of the datapath feeding the ALU subtract path.
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } neg_state_t;

  typedef logic [DATA_W-1:0] word_t;

  // Legal slice widths: a power of two from 8 to 64 that tiles the operand.
  function automatic bit chunk_w_ok(input int w);
    return ((w == 8) || (w == 16) || (w == 32) || (w == 64)) && ((DATA_W % w) == 0);
  endfunction

endpackage

// File: rtl/neg_chunk_inc.sv
// One slice of the sliced incrementer: sum = slice + cin, cout = carry out of the slice.
// Latency: combinational.
// Backpressure: none.
module neg_chunk_inc #(
  parameter int CHUNK_W = 16
) (
  input  logic [CHUNK_W-1:0] slice_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] sum_o,
  output logic               cout_o
);

  // Widen by one bit so the slice carry-out falls out of the add.
  assign {cout_o, sum_o} = {1'b0, slice_i} + {{CHUNK_W{1'b0}}, cin_i};

endmodule

// File: rtl/neg_increment_seq.sv
// Adds the +1 carry-in to an inverted operand (~a) to form -a, CHUNK_W bits per cycle.
// Latency: NUM_CHUNKS cycles from accept to out_valid (early exit on carry kill when
//          NEG_EARLY_DONE_EN is defined). Backpressure: single operand in flight; in_ready
//          is low from accept until the cycle after the output handshake.
module neg_increment_seq
  import neg_pkg::*;
#(
  parameter int CHUNK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic              out_ovf
);

  localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Reject slice widths that do not tile the operand at elaboration time.
  if (!chunk_w_ok(CHUNK_W)) begin : g_bad_chunk_w
    $error("neg_increment_seq: CHUNK_W must be 8, 16, 32 or 64");
  end

  neg_state_t       state_q;
  word_t            acc_q;
  word_t            acc_d;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             msb_q;
  logic             inc_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             out_carry_q;
  logic             out_ovf_q;

  int               slice_base;
  logic [CHUNK_W-1:0] slice_in;
  logic [CHUNK_W-1:0] slice_sum;
  logic             slice_cout;
  logic             last_slice;
  logic             finish;

  // Select the slice currently being incremented.
  always_comb begin
    slice_base = int'(idx_q) * CHUNK_W;
    slice_in   = acc_q[slice_base +: CHUNK_W];
  end

  neg_chunk_inc #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk_inc (
    .slice_i (slice_in),
    .cin_i   (carry_q),
    .sum_o   (slice_sum),
    .cout_o  (slice_cout)
  );

  // Next accumulator value: current slice replaced by its incremented form.
  always_comb begin
    acc_d = acc_q;
    acc_d[slice_base +: CHUNK_W] = slice_sum;
  end

  assign last_slice = (idx_q == LAST_IDX);

`ifdef NEG_EARLY_DONE_EN
  // Once the carry dies the upper slices are already final, so stop early.
  assign finish = last_slice | ~slice_cout;
`else
  assign finish = last_slice;
`endif

  // Control FSM plus datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      msb_q       <= 1'b0;
      inc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            acc_q       <= in_data;
            carry_q     <= inc_en;
            idx_q       <= '0;
            msb_q       <= in_data[DATA_W-1];
            inc_q       <= inc_en;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          acc_q   <= acc_d;
          carry_q <= slice_cout;
          idx_q   <= idx_q + IDX_ONE;
          if (finish) begin
            // Only the carry out of the top slice is a true carry out of bit 63.
            out_carry_q <= last_slice & slice_cout;
            out_ovf_q   <= inc_q & ~msb_q & acc_d[DATA_W-1];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_carry = out_carry_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_neg_increment_seq.sv
// Directed self-checking bench for neg_increment_seq (default CHUNK_W=16).
// Expected latencies follow NEG_EARLY_DONE_EN when the bench is built with it.
// Outputs sampled 1ns after the rising edge; inputs driven on the falling edge.
`timescale 1ns/1ps
module tb_neg_increment_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        inc_en;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_carry;
  logic        out_ovf;

  int errors = 0;
  int checks = 0;

`ifdef NEG_EARLY_DONE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  neg_increment_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inc_en    (inc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [63:0] d, input logic inc);
    @(negedge clk);
    chk({tag, "_rdy_before"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    inc_en   = inc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 64'd0;
    inc_en   = 1'b0;
    chk({tag, "_rdy_busy"}, 64'(in_ready), 64'd0);
  endtask

  // Counts rising edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [63:0] d, input logic inc,
                        input logic [63:0] exp_data, input logic exp_carry,
                        input logic exp_ovf, input int exp_lat);
    int lat;
    send(tag, d, inc);
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_carry"}, 64'(out_carry), 64'(exp_carry));
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
    handshake(tag);
  endtask

  initial begin
    int lat;
    int seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    inc_en    = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",   64'(out_valid), 64'd0);
    chk("rst_data",  out_data,       64'd0);
    chk("rst_carry", 64'(out_carry), 64'd0);
    chk("rst_ovf",   64'(out_ovf),   64'd0);
    chk("rst_rdy",   64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Negate 5.
    run_op("neg5", 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0,
           EARLY ? 1 : 4);
    // Negate 0: full wrap, carry out of bit 63.
    run_op("neg0", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 4);
    // Negate the most negative value: signed overflow.
    run_op("negmin", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4);
    // Passthrough.
    run_op("pass", 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0,
           EARLY ? 1 : 4);
    // Carry crossing exactly one slice boundary.
    run_op("xslice", 64'h0000_0000_0000_FFFF, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0,
           EARLY ? 2 : 4);

    // Backpressure: hold out_ready low in DONE, poke in_valid meanwhile.
    send("bp", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    wait_valid(lat);
    chk("bp_lat", 64'(lat), 64'(EARLY ? 1 : 4));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 3);
      in_data  = 64'h0000_0000_0000_0055;
      inc_en   = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_hold_vld",   64'(out_valid), 64'd1);
      chk("bp_hold_data",  out_data,       64'hFFFF_FFFF_FFFF_FFFD);
      chk("bp_hold_carry", 64'(out_carry), 64'd0);
      chk("bp_hold_ovf",   64'(out_ovf),   64'd0);
      chk("bp_hold_rdy",   64'(in_ready),  64'd0);
    end
    handshake("bp");
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("bp_no_ghost_op", 64'(seen), 64'd0);
    chk("bp_idle_rdy", 64'(in_ready), 64'd1);

    // Reset while BUSY at idx=2.
    send("rst_mid", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_busy_vld", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld",   64'(out_valid), 64'd0);
    chk("rst_mid_data",  out_data,       64'd0);
    chk("rst_mid_carry", 64'(out_carry), 64'd0);
    chk("rst_mid_ovf",   64'(out_ovf),   64'd0);
    chk("rst_mid_rdy",   64'(in_ready),  64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("rst_mid_no_vld", 64'(seen), 64'd0);

    // First operand after reset: ~7.
    run_op("post_rst", 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0,
           EARLY ? 1 : 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
